// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package serial_adder_pkg;

  localparam int unsigned NIBBLE = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_add.sv
// Combinational 4-bit adder slice with carry-in and carry-out.
module nibble_add
  import serial_adder_pkg::*;
(
  input  logic [NIBBLE-1:0] a_i,
  input  logic [NIBBLE-1:0] b_i,
  input  logic              cin_i,
  output logic [NIBBLE-1:0] s_o,
  output logic              c_o
);

  logic [NIBBLE:0] full;

  always_comb begin
    full = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE{1'b0}}, cin_i};
  end

  assign s_o = full[NIBBLE-1:0];
  assign c_o = full[NIBBLE];

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-cycle WIDTH-bit adder, one nibble per clock through a single slice.
// Define SERIAL_NIBBLE_ADDER_SUBTRACT_EN to add the sub_i port (a - b).
module serial_nibble_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef SERIAL_NIBBLE_ADDER_SUBTRACT_EN
  input  logic             sub_i,
`endif
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned N       = WIDTH / NIBBLE;
  localparam int unsigned IdxW    = $clog2(N);
  localparam int unsigned ResW    = WIDTH - NIBBLE;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  // Only the lower nibbles are stored; the top nibble comes straight from the slice.
  logic [ResW-1:0]   res_q, res_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  b_load;
  logic              cin_load;
  logic [NIBBLE-1:0] slice_s;
  logic              slice_c;
  logic [WIDTH-1:0]  res_cat;

`ifdef SERIAL_NIBBLE_ADDER_SUBTRACT_EN
  // Two's-complement subtract: a + ~b + 1.
  assign b_load   = sub_i ? ~b_i : b_i;
  assign cin_load = sub_i ? 1'b1 : cin_i;
`else
  assign b_load   = b_i;
  assign cin_load = cin_i;
`endif

  nibble_add u_nibble_add (
    .a_i   (a_q[NIBBLE-1:0]),
    .b_i   (b_q[NIBBLE-1:0]),
    .cin_i (carry_q),
    .s_o   (slice_s),
    .c_o   (slice_c)
  );

  assign res_cat = {slice_s, res_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_load;
          carry_d = cin_load;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> NIBBLE;
        b_d     = b_q >> NIBBLE;
        res_d   = res_cat[WIDTH-1:NIBBLE];
        carry_d = slice_c;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          sum_d   = res_cat;
          cout_d  = slice_c;
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign ready_o = (state_q == StIdle);
  assign done_o  = done_q;
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;

endmodule
